erasable_mem_responder: RTL

- Memory-side responder for the erasable store; the other end of the S-register / G-bus / parity interface driven by the address-and-parity module.
- Latches the 12-bit S address and the E-bank bits on a cycle start and decodes them to one of 2048 erasable words.
- Runs a fixed 12-step memory cycle: sense (read) at an early step, then restore or rewrite at a late step.
- Returns the 15-bit word plus its stored parity bit; optionally checks odd parity on readout.

---
 rtl/erasable_mem_responder.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/erasable_mem_responder.sv
// Erasable-store responder: 12-step sense/restore cycle over 2048 words; ERASABLE_PARITY_CHECK_EN adds a sticky odd-parity alarm.
// Latency: read data valid at step RD_STEP, commit on the edge leaving WR_STEP, done at step TSTEPS.
// Backpressure: none; mstart is accepted only at idle or the final step, otherwise it raises overrun and is dropped.
module erasable_mem_responder #(
   parameter int TSTEPS  = 12,
   parameter int RD_STEP = 4,
   parameter int WR_STEP = 10,
   parameter int NBANKS  = 8
) (
   input  logic                        clk,
   input  logic                        rst_,
   input  logic                        mstart,
   input  logic [11:0]                 s,
   input  logic [$clog2(NBANKS)-1:0]   eb,
   input  logic                        wstrobe,
   input  logic [14:0]                 wdata,
   input  logic                        wpar,
   output logic                        busy,
   output logic                        hit,
   output logic                        rvalid,
   output logic [14:0]                 rdata,
   output logic                        rpar,
   output logic                        done,
   output logic                        overrun,
   output logic                        par_alm
);

   localparam int EBW   = $clog2(NBANKS);
   localparam int AW    = EBW + 8;
   localparam int DEPTH = 1 << AW;
   localparam int SW    = $clog2(TSTEPS + 1);

   localparam logic [SW-1:0] LP_LAST   = SW'(TSTEPS);
   localparam logic [SW-1:0] LP_PRE_RD = SW'(RD_STEP - 1);
   localparam logic [SW-1:0] LP_WIN_LO = SW'(RD_STEP + 1);
   localparam logic [SW-1:0] LP_WIN_HI = SW'(WR_STEP - 1);
   localparam logic [SW-1:0] LP_WR     = SW'(WR_STEP);

   logic [SW-1:0]  r_step;
   logic           r_hit;
   logic [AW-1:0]  r_idx;
   logic           r_rvalid;
   logic [14:0]    r_rdata;
   logic           r_rpar;
   logic           r_overrun;
   logic           r_wflag;
   logic [14:0]    r_wdata;
   logic           r_wpar;
   logic [15:0]    r_mem [0:DEPTH-1];

   logic           w_dec_hit;
   logic [AW-1:0]  w_dec_idx;
   logic           w_last;
   logic           w_accept;
   logic           w_sense;
   logic           w_in_win;
   logic [15:0]    w_rd_word;

   // Octal address map: central regs, unswitched erasable, banked erasable, fixed.
   always_comb begin
      w_dec_hit = 1'b0;
      w_dec_idx = '0;
      if (s >= 12'o0010 && s <= 12'o1377) begin
         w_dec_hit = 1'b1;
         w_dec_idx = AW'(s[10:0]);
      end else if (s >= 12'o1400 && s <= 12'o1777) begin
         w_dec_hit = 1'b1;
         w_dec_idx = {eb, s[7:0]};
      end
   end

   assign w_last    = (r_step == LP_LAST);
   assign w_accept  = mstart && ((r_step == '0) || w_last);
   assign w_sense   = r_hit && (r_step == LP_PRE_RD);
   assign w_in_win  = (r_step >= LP_WIN_LO) && (r_step <= LP_WIN_HI);
   assign w_rd_word = r_mem[r_idx];

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         r_step    <= '0;
         r_hit     <= 1'b0;
         r_idx     <= '0;
         r_rvalid  <= 1'b0;
         r_rdata   <= '0;
         r_rpar    <= 1'b0;
         r_overrun <= 1'b0;
         r_wflag   <= 1'b0;
         r_wdata   <= '0;
         r_wpar    <= 1'b0;
      end else begin
         r_rvalid  <= 1'b0;
         r_overrun <= mstart && (r_step != '0) && !w_last;

         if (w_accept) begin
            r_step <= SW'(1);
            r_hit  <= w_dec_hit;
            r_idx  <= w_dec_idx;
         end else if (w_last) begin
            r_step <= '0;
            r_hit  <= 1'b0;
         end else if (r_step != '0) begin
            r_step <= r_step + SW'(1);
         end

         if (w_sense) begin
            r_rdata  <= w_rd_word[14:0];
            r_rpar   <= w_rd_word[15];
            r_rvalid <= 1'b1;
         end

         // Last strobe inside the window wins; the flag outlives the commit until the final step.
         if (w_last) begin
            r_wflag <= 1'b0;
         end else if (wstrobe && w_in_win) begin
            r_wflag <= 1'b1;
            r_wdata <= wdata;
            r_wpar  <= wpar;
         end
      end
   end

   // Destructive-readout model: the word is always rewritten, either restored or replaced.
   always_ff @(posedge clk) begin
      if (r_hit && (r_step == LP_WR)) begin
         r_mem[r_idx] <= r_wflag ? {r_wpar, r_wdata} : {r_rpar, r_rdata};
      end
   end

`ifdef ERASABLE_PARITY_CHECK_EN
   logic r_par_alm;

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         r_par_alm <= 1'b0;
      end else if (w_sense && !(^w_rd_word)) begin
         r_par_alm <= 1'b1;
      end
   end

   assign par_alm = r_par_alm;
`else
   assign par_alm = 1'b0;
`endif

   assign busy    = (r_step != '0);
   assign hit     = r_hit;
   assign rvalid  = r_rvalid;
   assign rdata   = r_rdata;
   assign rpar    = r_rpar;
   assign done    = w_last;
   assign overrun = r_overrun;

endmodule
